// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector.
// Per-channel mode encoding and the edge acceptance helper.
package edge_detect_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  function automatic logic mode_accepts(mode_t m, logic r, logic f);
    return (r & m[0]) | (f & m[1]);
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchroniser, optional debounce (EDGE_DETECT_DEBOUNCE_EN),
// level/level-delay registers and mode-qualified edge strobes.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  din,
  input  mode_t mode,
  output logic  level,
  output logic  rise,
  output logic  fall,
  output logic  pulse
);

`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int CHAIN = SYNC_STAGES;
`else
  // Without debounce the level flop itself is the last synchroniser stage.
  localparam int CHAIN = SYNC_STAGES - 1;
`endif

  logic [CHAIN-1:0] sync_q, sync_d;
  logic             s;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;

  if (CHAIN > 1) begin : g_chain
    assign sync_d = {sync_q[CHAIN-2:0], din};
  end else begin : g_one
    assign sync_d = din;
  end

  assign s = sync_q[CHAIN-1];

`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (s != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d  = s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) db_cnt_q <= '0;
    else       db_cnt_q <= db_cnt_d;
  end
`else
  always_comb begin
    level_d = s;
  end
`endif

  always_comb begin
    level_dly_d = level_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;
  assign fall  = ~level_q & level_dly_q;
  assign pulse = mode_accepts(mode, rise, fall);

endmodule

// File: rtl/edge_detect_array.sv
// WIDTH-channel edge detector: per-channel detect plus sticky pending,
// irq and a saturating accepted-event counter. Debounce via EDGE_DETECT_DEBOUNCE_EN.
module edge_detect_array
  import edge_detect_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clear,
  input  logic               count_clr,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   pending,
  output logic               irq,
  output logic [CNT_W-1:0]   count
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock(clock),
      .reset(reset),
      .din  (din[i]),
      .mode (mode_t'(mode[2*i +: 2])),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .pulse(pulse[i])
    );
  end

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   inc, sum;

  // Set beats clear: a pulse in the clearing cycle keeps the flag.
  always_comb begin
    pending_d = (pending_q & ~clear) | pulse;
  end

  // Clear applies before the add; one extra bit catches overflow.
  always_comb begin
    inc = '0;
    for (int i = 0; i < WIDTH; i++) inc = inc + (CNT_W+1)'(pulse[i]);
    sum     = {1'b0, (count_clr ? '0 : count_q)} + inc;
    count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending = pending_q;
  assign irq     = |pending_q;
  assign count   = count_q;

endmodule
